// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the 4-bit carry-lookahead equation.
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Carry into bit n of a 4-bit group, expanded from generate/propagate terms.
  function automatic logic cla_carry(input logic [3:0] g, input logic [3:0] p,
                                     input logic cin, input int n);
    logic c;
    c = cin;
    for (int m = 0; m < 4; m++) begin
      if (m < n) c = g[m] | (p[m] & c);
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_divider_cla_sub.sv
// Combinational carry-lookahead subtractor a - b computed as a + ~b + 1.
// borrow_n is the final carry: 1 means a >= b (no borrow).
module cla_sub
  import seq_div_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_n
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0]    g;
  logic [W-1:0]    p;
  logic [NG*4-1:0] g_pad;
  logic [NG*4-1:0] p_pad;
  logic [W:0]      c;

  assign g     = a & ~b;
  assign p     = a ^ ~b;
  assign g_pad = (NG*4)'(g);
  assign p_pad = (NG*4)'(p);
  assign c[0]  = 1'b1;

  // Lookahead inside each 4-bit group, group carries chained between groups.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int LO  = 4 * k;
    localparam int LEN = ((W - LO) >= 4) ? 4 : (W - LO);
    for (genvar n = 1; n <= LEN; n++) begin : g_bit
      assign c[LO+n] = cla_carry(g_pad[LO+:4], p_pad[LO+:4], c[LO], n);
    end
  end

  assign diff     = p ^ c[W-1:0];
  assign borrow_n = c[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle,
// results published on the single done cycle and held until the next start.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow_n;
  logic             diff_msb_unused;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // Shift {partial remainder, dividend} left and trial-subtract the divisor.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  cla_sub #(
    .W(WIDTH + 1)
  ) u_sub (
    .a        (shifted),
    .b        ({1'b0, dsr_q}),
    .diff     (diff),
    .borrow_n (borrow_n)
  );

  // A successful trial always leaves the partial remainder below the divisor.
  assign diff_msb_unused = diff[WIDTH];

  always_comb begin
    rem_d = shifted[WIDTH-1:0];
    if (borrow_n) rem_d = diff[WIDTH-1:0];
    dvd_d = {dvd_q[WIDTH-2:0], borrow_n};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              quo_out_q <= '1;
              rem_out_q <= dividend;
              dbz_q     <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
              cnt_q   <= '0;
              rem_q   <= '0;
              dvd_q   <= dividend;
              dsr_q   <= divisor;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            quo_out_q <= dvd_d;
            rem_out_q <= rem_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule
